// File: rtl/distram_pkg.sv
// distram_pkg: shared constants and reader state type for the 256-deep distributed RAM.
package distram_pkg;
    localparam int DISTRAM_DEPTH  = 256;
    localparam int DISTRAM_ADDR_W = 8;
    localparam int DISTRAM_DATA_W = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} reader_state_t;
endpackage

// File: rtl/distram_stream_outreg.sv
// distram_stream_outreg: stream holding register; DISTRAM_STREAM_READER_PARITY_EN adds parity.
module distram_stream_outreg
    import distram_pkg::*;
#(
    parameter int DATA_WIDTH = DISTRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  last_in,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
`ifdef DISTRAM_STREAM_READER_PARITY_EN
    output logic                  parity,
`endif
    output logic                  last
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
            last  <= last_in;
        end else if (clear) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end
`ifdef DISTRAM_STREAM_READER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            parity <= 1'b0;
        else if (load)
            parity <= ^d;
    end
`endif
endmodule

// File: rtl/distram_stream_reader.sv
// distram_stream_reader: burst reader on RAM port B to valid/ready stream (DISTRAM_STREAM_READER_PARITY_EN adds out_parity).
module distram_stream_reader
    import distram_pkg::*;
#(
    parameter int DATA_WIDTH = DISTRAM_DATA_W,
    parameter int ADDR_WIDTH = DISTRAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rddata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
`ifdef DISTRAM_STREAM_READER_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  busy,
    output logic                  done
);
    reader_state_t         state, state_n;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   rem;
    logic                  accept, start, xfer, load, done_n;
    assign accept   = cmd_valid && cmd_ready;
    assign start    = accept && cmd_len != '0;
    assign xfer     = out_valid && out_ready;
    assign ram_addr = ptr;
    assign busy     = state != ST_IDLE;
    always_comb begin
        state_n = state;
        load    = 1'b0;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                done_n  = accept && cmd_len == '0;
                state_n = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                load    = rem != '0 && (!out_valid || out_ready);
                state_n = (load && rem == (ADDR_WIDTH+1)'(1)) ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                done_n  = xfer;
                state_n = xfer ? ST_IDLE : ST_DRAIN;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // ready is registered so it stays low through reset and the done cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            rem       <= '0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_n;
            done      <= done_n;
            cmd_ready <= state_n == ST_IDLE && !done_n;
            if (state == ST_IDLE && start) begin
                ptr <= cmd_addr;
                rem <= cmd_len;
            end else if (load) begin
                ptr <= ptr + 1'b1;
                rem <= rem - 1'b1;
            end
        end
    end
    distram_stream_outreg #(.DATA_WIDTH(DATA_WIDTH)) u_outreg (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .clear   (xfer && !load),
        .d       (ram_rddata),
        .last_in (rem == (ADDR_WIDTH+1)'(1)),
        .valid   (out_valid),
        .data    (out_data),
`ifdef DISTRAM_STREAM_READER_PARITY_EN
        .parity  (out_parity),
`endif
        .last    (out_last)
    );
endmodule

// File: tb/tb_distram_stream_reader.sv
// tb_distram_stream_reader: directed scoreboard bench for distram_stream_reader with a behavioural RAM.
module tb_distram_stream_reader;
    logic        clk = 0, reset = 1, cmd_valid = 0, out_ready = 1;
    logic        cmd_ready, out_valid, out_last, busy, done;
    logic [7:0]  cmd_addr = 0, ram_addr;
    logic [8:0]  cmd_len = 0;
    logic [31:0] ram_rddata, out_data;
`ifdef DISTRAM_STREAM_READER_PARITY_EN
    logic        out_parity;
`endif
    logic [31:0] mem [256];
    logic [33:0] sb [$];
    int          total = 0, bad = 0, beats = 0, dcnt = 0, cyc = 0, b0 = 0, d0 = 0, rdy_busy = 0;
    logic        hold_v = 0, hold_l = 0;
    logic [31:0] hold_d = 0;
    int          pat [6] = '{1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;
    assign ram_rddata = mem[ram_addr];

    distram_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .ram_addr   (ram_addr),
        .ram_rddata (ram_rddata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
`ifdef DISTRAM_STREAM_READER_PARITY_EN
        .out_parity (out_parity),
`endif
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [33:0] e;
        @(negedge clk);
        if (hold_v) begin
            chk("hold_data", 64'(out_data), 64'(hold_d));
            chk("hold_last", 64'(out_last), 64'(hold_l));
        end
        if (out_valid && out_ready) begin
            beats++;
            if (sb.size() == 0)
                chk("sb_unexpected_beat", 64'(sb.size()), 64'(1));
            else begin
                e = sb.pop_front();
                chk("beat_data", 64'(out_data), 64'(e[31:0]));
                chk("beat_last", 64'(out_last), 64'(e[32]));
`ifdef DISTRAM_STREAM_READER_PARITY_EN
                chk("beat_parity", 64'(out_parity), 64'(e[33]));
`endif
            end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (done) dcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input int n);
        logic [31:0] w;
        chk("cmd_ready_at_issue", 64'(cmd_ready), 64'(1));
        cmd_valid = 1;
        cmd_addr  = a;
        cmd_len   = 9'(n);
        for (int i = 0; i < n; i++) begin
            w = mem[8'(int'(a) + i)];
            sb.push_back({^w, i == n - 1, w});
        end
        step();
        cmd_valid = 0;
    endtask

    task automatic run_until_done(input int budget, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (!done && c < budget);
        chk("done_seen", 64'(done), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        reset  = 0;
        hold_v = 0;
        step();
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        b0 = beats;
        issue(8'h10, 4);
        chk("t1_no_valid_after_accept", 64'(out_valid), 64'(0));
        chk("t1_ram_addr", 64'(ram_addr), 64'(8'h10));
        run_until_done(20, cyc);
        chk("t1_cycles", 64'(cyc), 64'(5));
        chk("t1_beats", 64'(beats - b0), 64'(4));
        chk("t1_ready_in_done", 64'(cmd_ready), 64'(0));
        step();
        chk("t1_done_one_cycle", 64'(done), 64'(0));
        chk("t1_ready_back", 64'(cmd_ready), 64'(1));

        b0 = beats;
        issue(8'hFE, 4);
        chk("wrap_addr_start", 64'(ram_addr), 64'(8'hFE));
        step();
        step();
        chk("wrap_addr_zero", 64'(ram_addr), 64'(8'h00));
        run_until_done(20, cyc);
        chk("wrap_beats", 64'(beats - b0), 64'(4));
        step();

        b0 = beats;
        issue(8'h20, 3);
        foreach (pat[i]) begin
            out_ready = pat[i][0];
            step();
        end
        out_ready = 1;
        run_until_done(20, cyc);
        chk("stall_beats", 64'(beats - b0), 64'(3));
        chk("stall_sb_empty", 64'(sb.size()), 64'(0));
        step();

        b0 = beats;
        d0 = dcnt;
        issue(8'h05, 0);
        chk("len0_done", 64'(done), 64'(1));
        chk("len0_no_valid", 64'(out_valid), 64'(0));
        chk("len0_busy", 64'(busy), 64'(0));
        step();
        chk("len0_done_once", 64'(dcnt - d0), 64'(1));
        chk("len0_ready_back", 64'(cmd_ready), 64'(1));
        chk("len0_no_beats", 64'(beats - b0), 64'(0));

        b0 = beats;
        issue(8'h40, 8);
        cmd_valid = 1;
        cmd_addr  = 8'h80;
        cmd_len   = 9'd2;
        rdy_busy  = 0;
        cyc       = 0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            if (busy && cmd_ready) rdy_busy++;
        end
        chk("busy_cmd_done", 64'(done), 64'(1));
        chk("busy_cmd_ignored", 64'(rdy_busy), 64'(0));
        chk("busy_cmd_ready_in_done", 64'(cmd_ready), 64'(0));
        chk("busy_burst_beats", 64'(beats - b0), 64'(8));
        step();
        b0 = beats;
        issue(8'h80, 2);
        run_until_done(20, cyc);
        chk("second_cmd_cycles", 64'(cyc), 64'(3));
        chk("second_cmd_beats", 64'(beats - b0), 64'(2));
        step();

        b0 = beats;
        issue(8'h60, 8);
        repeat (3) step();
        chk("midrst_beats_before", 64'(beats - b0), 64'(2));
        d0 = dcnt;
        out_ready = 0;
        reset = 1;
        step();
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        hold_v = 0;
        sb.delete();
        reset = 0;
        out_ready = 1;
        step();
        step();
        chk("midrst_no_done_pulse", 64'(dcnt - d0), 64'(0));
        chk("midrst_ready", 64'(cmd_ready), 64'(1));

        b0 = beats;
        issue(8'h00, 256);
        run_until_done(400, cyc);
        chk("full_cycles", 64'(cyc), 64'(257));
        chk("full_beats", 64'(beats - b0), 64'(256));
        chk("full_sb_empty", 64'(sb.size()), 64'(0));
        step();

`ifdef DISTRAM_STREAM_READER_PARITY_EN
        mem[8'h30] = 32'h00000007;
        mem[8'h31] = 32'h00000003;
        b0 = beats;
        issue(8'h30, 2);
        step();
        chk("parity_odd_word", 64'(out_parity), 64'(1));
        run_until_done(20, cyc);
        chk("parity_beats", 64'(beats - b0), 64'(2));
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
